// File: rtl/water_level_array.sv
// Float-switch array: per-channel 2-flop sync and debounce, then a wet-level
// code and a non-monotonic fault flag with a sticky copy.
`timescale 1ns/1ps
module water_level_array #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int STABLE_MS = 20,
  parameter int N_CH      = 4,
  localparam int LIMIT    = (CLK_FREQ / 1000) * STABLE_MS,
  localparam int CW       = $clog2(LIMIT + 1),
  localparam int LW       = $clog2(N_CH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] sensor_async,
  input  logic            fault_clr,
  output logic [N_CH-1:0] level_stable,
  output logic [N_CH-1:0] change_pulse,
  output logic [LW-1:0]   level_code,
  output logic            fault,
  output logic            fault_sticky
);

  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [N_CH-1:0] sync_meta;
  logic [N_CH-1:0] sync;
  logic [CW-1:0]   cnt [N_CH];
  logic [LW-1:0]   code_d;
  logic            fault_d;
  logic            seen_dry;

  // Reset value is "dry" so the array reads empty out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '1;
      sync      <= '1;
    end else begin
      sync_meta <= sensor_async;
      sync      <= sync_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_CH; i++) cnt[i] <= '0;
      level_stable <= '1;
      change_pulse <= '0;
    end else begin
      change_pulse <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (sync[i] == level_stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] < LIMIT_C) begin
          cnt[i] <= cnt[i] + CW'(1);
        end else begin
          level_stable[i] <= sync[i];
          change_pulse[i] <= 1'b1;
          cnt[i]          <= '0;
        end
      end
    end
  end

  // One upward scan: wet below the first dry channel counts toward the code;
  // any wet channel above a dry one is a fault and is not counted.
  always_comb begin
    code_d   = '0;
    fault_d  = 1'b0;
    seen_dry = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (level_stable[i]) begin
        seen_dry = 1'b1;
      end else if (seen_dry) begin
        fault_d = 1'b1;
      end else begin
        code_d = LW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_code   <= '0;
      fault        <= 1'b0;
      fault_sticky <= 1'b0;
    end else begin
      level_code   <= code_d;
      fault        <= fault_d;
      fault_sticky <= fault | (fault_sticky & ~fault_clr);
    end
  end

endmodule

// File: tb/tb_water_level_array.sv
// Self-checking bench for water_level_array at N_CH=3, LIMIT=4.
`timescale 1ns/1ps
module tb_water_level_array;

  localparam int N   = 3;
  localparam int LIM = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] sensor_async;
  logic         fault_clr;
  logic [N-1:0] level_stable;
  logic [N-1:0] change_pulse;
  logic [1:0]   level_code;
  logic         fault;
  logic         fault_sticky;

  int total = 0;
  int bad   = 0;

  water_level_array #(
    .CLK_FREQ (1000),
    .STABLE_MS(4),
    .N_CH     (N)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sensor_async(sensor_async),
    .fault_clr   (fault_clr),
    .level_stable(level_stable),
    .change_pulse(change_pulse),
    .level_code  (level_code),
    .fault       (fault),
    .fault_sticky(fault_sticky)
  );

  always #5 clk = ~clk;

  // Reference model: a channel commits when the raw samples taken 2..LIM+2
  // edges ago all disagree with its stable value.
  logic [N-1:0] hist [0:LIM+2];
  logic [N-1:0] m_stable, m_pulse;
  logic [1:0]   m_code;
  logic         m_fault, m_sticky;

  function automatic logic [N-1:0] commits();
    logic [N-1:0] c = '1;
    for (int j = 1; j <= LIM + 1; j++) c &= hist[j] ^ m_stable;
    return c;
  endfunction

  function automatic int ref_code(logic [N-1:0] v);
    if (v == '0) return N;
    return $clog2(int'(v & (~v + 3'd1)));
  endfunction

  function automatic logic ref_fault(logic [N-1:0] v);
    int ideal = (7 << ref_code(v)) & 7;
    return int'(v) != ideal;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j <= LIM + 2; j++) hist[j] <= '1;
      m_stable <= '1;
      m_pulse  <= '0;
      m_code   <= '0;
      m_fault  <= 1'b0;
      m_sticky <= 1'b0;
    end else begin
      m_sticky <= m_fault | (m_sticky & ~fault_clr);
      m_code   <= 2'(ref_code(m_stable));
      m_fault  <= ref_fault(m_stable);
      m_pulse  <= commits();
      m_stable <= m_stable ^ commits();
      hist[0]  <= sensor_async;
      for (int j = 1; j <= LIM + 2; j++) hist[j] <= hist[j-1];
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; sensor_async = '1; fault_clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; sensor_async = 3'b000; fault_clr = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({level_stable, change_pulse, level_code, fault, fault_sticky} !== 10'b111_000_00_0_0) begin
      bad++;
      $display("FAIL reset_state: got %b want %b", {level_stable, change_pulse, level_code, fault, fault_sticky}, 10'b111_000_00_0_0);
    end
    sensor_async = 3'b111;
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      total++;
      if (change_pulse !== 3'b000 || level_stable !== 3'b111) begin
        bad++;
        $display("FAIL release_no_pulse: edge %0d got pulse=%b stable=%b want 000/111", e, change_pulse, level_stable);
      end
    end
  endtask

  task automatic test_single_ch0();
    do_reset();
    sensor_async = 3'b110;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      total++;
      if (level_stable !== ((e >= 7) ? 3'b110 : 3'b111)) begin
        bad++;
        $display("FAIL ch0_latency: edge %0d got %b want %b", e, level_stable, (e >= 7) ? 3'b110 : 3'b111);
      end
      total++;
      if (change_pulse !== ((e == 7) ? 3'b001 : 3'b000)) begin
        bad++;
        $display("FAIL ch0_pulse: edge %0d got %b want %b", e, change_pulse, (e == 7) ? 3'b001 : 3'b000);
      end
      total++;
      if (level_code !== ((e >= 8) ? 2'd1 : 2'd0)) begin
        bad++;
        $display("FAIL ch0_code: edge %0d got %0d want %0d", e, level_code, (e >= 8) ? 1 : 0);
      end
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    do_reset();
    sensor_async = 3'b110;
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk);
      if (change_pulse[0]) pulses++;
      total++;
      if (level_stable[0] !== ((e >= 12) ? 1'b0 : 1'b1) || change_pulse[0] !== (e == 12)) begin
        bad++;
        $display("FAIL glitch_restart: edge %0d got stable0=%b pulse0=%b want %b/%b", e, level_stable[0], change_pulse[0], (e >= 12) ? 1'b0 : 1'b1, e == 12);
      end
      if (e == 4) sensor_async = 3'b111;
      if (e == 5) sensor_async = 3'b110;
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL glitch_pulse_count: got %0d want 1", pulses);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    sensor_async = 3'b000;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      total++;
      if ({level_stable, change_pulse, level_code, fault} !==
          {((e >= 7) ? 3'b000 : 3'b111), ((e == 7) ? 3'b111 : 3'b000), ((e >= 8) ? 2'd3 : 2'd0), 1'b0}) begin
        bad++;
        $display("FAIL simultaneous: edge %0d got stable=%b pulse=%b code=%0d fault=%b", e, level_stable, change_pulse, level_code, fault);
      end
    end
  endtask

  task automatic test_fault();
    do_reset();
    sensor_async = 3'b011;
    repeat (9) @(negedge clk);
    total++;
    if ({level_stable, level_code, fault, fault_sticky} !== 7'b011_00_1_1) begin
      bad++;
      $display("FAIL fault_set: got %b want %b", {level_stable, level_code, fault, fault_sticky}, 7'b011_00_1_1);
    end
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    total++;
    if (fault_sticky !== 1'b1) begin
      bad++;
      $display("FAIL sticky_set_priority: got %b want 1", fault_sticky);
    end
    sensor_async = 3'b111;
    repeat (8) @(negedge clk);
    total++;
    if ({fault, fault_sticky, level_code} !== 4'b0_1_00) begin
      bad++;
      $display("FAIL sticky_hold: got %b want %b", {fault, fault_sticky, level_code}, 4'b0_1_00);
    end
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    total++;
    if (fault_sticky !== 1'b0) begin
      bad++;
      $display("FAIL sticky_clear: got %b want 0", fault_sticky);
    end
  endtask

  task automatic test_reset_midcount();
    do_reset();
    sensor_async = 3'b101;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (level_stable !== 3'b111 || change_pulse !== 3'b000) begin
      bad++;
      $display("FAIL midcount_reset: got stable=%b pulse=%b want 111/000", level_stable, change_pulse);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      total++;
      if (level_stable !== ((e >= 7) ? 3'b101 : 3'b111) || change_pulse !== ((e == 7) ? 3'b010 : 3'b000)) begin
        bad++;
        $display("FAIL midcount_restart: edge %0d got stable=%b pulse=%b", e, level_stable, change_pulse);
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      total++;
      if ({level_stable, change_pulse, level_code, fault, fault_sticky} !==
          {m_stable, m_pulse, m_code, m_fault, m_sticky}) begin
        bad++;
        $display("FAIL random_vs_model: cycle %0d got %b want %b", c,
                 {level_stable, change_pulse, level_code, fault, fault_sticky},
                 {m_stable, m_pulse, m_code, m_fault, m_sticky});
      end
      if (hold == 0) begin
        sensor_async = 3'($urandom);
        hold = $urandom_range(1, 12);
      end else begin
        hold--;
      end
      fault_clr = ($urandom_range(0, 7) == 0);
      reset     = ($urandom_range(0, 499) == 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sensor_async = '1; fault_clr = 1'b0;
    test_reset();
    test_single_ch0();
    test_glitch();
    test_simultaneous();
    test_fault();
    test_reset_midcount();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/water_level_array.md
WATER_LEVEL_ARRAY -- requirements
Module: water_level_array

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter STABLE_MS, default 20, meaning the debounce stable time in ms.
REQ-003 The block SHALL have parameter N_CH, default 4, meaning the number of float switches, ordered bottom (ch 0) to top (ch N_CH-1), range 1..16.
REQ-004 The block SHALL use derived constants LIMIT = (CLK_FREQ/1000)*STABLE_MS, CW = $clog2(LIMIT+1) and LW = $clog2(N_CH+1).
REQ-005 clk  input  1  system clock; all state on its rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 sensor_async  input  N_CH  raw switch levels, unsynchronised; 1 = dry, 0 = wet.
REQ-008 fault_clr  input  1  synchronous single-cycle clear of fault_sticky.
REQ-009 level_stable  output  N_CH  debounced switch levels; 1 = dry.
REQ-010 change_pulse  output  N_CH  one-cycle strobe per channel when its level_stable bit toggles.
REQ-011 level_code  output  LW  count of contiguous wet switches from ch 0 upward.
REQ-012 fault  output  1  current stable vector is non-monotonic.
REQ-013 fault_sticky  output  1  latched fault, held until fault_clr.

Function
REQ-014 Each channel SHALL pass through its own 2-flop synchroniser; the synchroniser output is sync[i].
REQ-015 Each channel SHALL own an independent CW-bit counter, cnt[i].
REQ-016 When sync[i] == level_stable[i], cnt[i] SHALL load 0.
REQ-017 When sync[i] != level_stable[i] and cnt[i] < LIMIT, cnt[i] SHALL increment by 1.
REQ-018 When sync[i] != level_stable[i] and cnt[i] == LIMIT, level_stable[i] SHALL take sync[i] and cnt[i] SHALL load 0.
REQ-019 From REQ-016 to REQ-018, a toggle SHALL commit on the (LIMIT+1)th consecutive mismatching clk; any single matching cycle restarts the count.
REQ-020 Latency from a sensor_async edge to the level_stable update SHALL be LIMIT+3 clk cycles: 2 synchroniser cycles plus LIMIT+1 debounce cycles.
REQ-021 change_pulse[i] SHALL be registered and high for exactly the one cycle following the clk edge that updates level_stable[i].
REQ-022 Multiple channels MAY commit in the same cycle; each SHALL pulse independently.
REQ-023 cnt[i] SHALL never exceed LIMIT and SHALL never wrap.
REQ-024 level_code SHALL be registered, one cycle after level_stable.
REQ-025 level_code SHALL equal the largest k such that channels 0..k-1 are all wet (0); all dry gives 0 and all wet gives N_CH.
REQ-026 fault SHALL be registered, one cycle after level_stable.
REQ-027 fault SHALL be 1 iff there exist i > j with channel i wet and channel j dry.
REQ-028 fault_sticky SHALL set on any cycle where fault is 1.
REQ-029 fault_sticky SHALL clear on fault_clr only if fault is 0 in that cycle; set has priority over clear.
REQ-030 level_code SHALL ignore channels above the first dry channel, including while fault is 1.

Reset
REQ-031 While reset is high, the synchroniser flops and level_stable SHALL be all 1s (empty).
REQ-032 While reset is high, all cnt SHALL be 0.
REQ-033 While reset is high, change_pulse SHALL be 0, level_code SHALL be 0, fault SHALL be 0 and fault_sticky SHALL be 0.
REQ-034 Reset asserted mid-count SHALL discard partial counts.
REQ-035 Release of reset SHALL NOT generate change_pulse.

Verification (N_CH=3, CLK_FREQ=1000, STABLE_MS=4, so LIMIT=4)
REQ-036 Reset, then sensor_async=3'b110 held -> level_stable[0] goes 0 exactly 7 clk after the edge; change_pulse=3'b001 for 1 cycle; level_code=1 one cycle later.
REQ-037 ch0 wet for 4 cycles, 1 cycle dry, then wet -> no toggle until 5 consecutive synced wet cycles; single pulse.
REQ-038 sensor_async 3'b111 -> 3'b000 simultaneously -> all three bits update in the same cycle; change_pulse=3'b111; level_code=3.
REQ-039 Stable 3'b011 (ch2 wet only) -> fault=1, fault_sticky=1, level_code=0; fault_clr while fault=1 -> fault_sticky stays 1; restore 3'b111, then fault_clr -> fault_sticky=0.
REQ-040 Reset asserted with cnt[1]=3 -> after release, cnt restarts and a full 5-cycle mismatch is required; no pulse at release.
REQ-041 Default parameters -> commit after 1_000_001 mismatching cycles; no counter wrap over 2_000_000 cycles of held mismatch.
